// File: rtl/execute_unit_pkg.sv
// Shared definitions for the execute stage.
//   alu_op_e    : ALU operation codes carried in the 3-bit ALUControl field
//   fwd_sel_e   : operand forwarding select codes
//   mul_state_e : iterative multiplier state encoding
//   ctrl_t      : decode control bundle carried through the D->E register
package execute_unit_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_MUL = 3'b011,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG      = 2'b00,
    FWD_RESULT_W = 2'b01,
    FWD_ALUOUT_M = 2'b10,
    FWD_REG_ALT  = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_RUN  = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic [2:0] alu_control;
  } ctrl_t;

endpackage

// File: rtl/execute_unit_dtoeff.sv
// DTOEFF: decode-to-execute pipeline register.
//   clk, rst_n      : clock, asynchronous active-low reset
//   en              : capture enable (low = hold)
//   clr             : synchronous clear to a bubble, overrides en
//   ctrl_d..rd_d    : decode-stage control, operands, immediate, specifiers
//   ctrl_e..rd_e    : registered execute-stage copies
module DTOEFF
  import execute_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  ctrl_t            ctrl_d,
  input  logic [WIDTH-1:0] r1_d,
  input  logic [WIDTH-1:0] r2_d,
  input  logic [WIDTH-1:0] imm_d,
  input  logic [4:0]       rs_d,
  input  logic [4:0]       rt_d,
  input  logic [4:0]       rd_d,
  output ctrl_t            ctrl_e,
  output logic [WIDTH-1:0] r1_e,
  output logic [WIDTH-1:0] r2_e,
  output logic [WIDTH-1:0] imm_e,
  output logic [4:0]       rs_e,
  output logic [4:0]       rt_e,
  output logic [4:0]       rd_e
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_e <= '0;
      r1_e   <= '0;
      r2_e   <= '0;
      imm_e  <= '0;
      rs_e   <= '0;
      rt_e   <= '0;
      rd_e   <= '0;
    end else if (clr) begin
      ctrl_e <= '0;
      r1_e   <= '0;
      r2_e   <= '0;
      imm_e  <= '0;
      rs_e   <= '0;
      rt_e   <= '0;
      rd_e   <= '0;
    end else if (en) begin
      ctrl_e <= ctrl_d;
      r1_e   <= r1_d;
      r2_e   <= r2_d;
      imm_e  <= imm_d;
      rs_e   <= rs_d;
      rt_e   <= rt_d;
      rd_e   <= rd_d;
    end
  end

endmodule

// File: rtl/execute_unit.sv
// execute_unit: pipeline execute stage (D->E register, forwarding muxes, ALU,
// optional iterative shift-add multiplier).
// Optional feature macro: EXECUTE_UNIT_MULT_EN enables the multiply FSM and
// ALU op 011; without it op 011 returns 0 and EU_BusyE is tied low.
//   EU_CLK, EU_RST             : clock, asynchronous active-low reset
//   EU_*D                      : decode-stage control, operands, specifiers
//   EU_StallE, EU_FlushE       : hold / bubble the D->E register
//   EU_ForwardAE/BE            : operand select (00/11 reg, 01 ResultW, 10 ALUOutM)
//   EU_ALUOutM, EU_ResultW     : forwarded values from later stages
//   EU_ALUOutE, EU_WriteDataE  : ALU result, forwarded R2
//   EU_WriteRegE, EU_RsE/RtE   : destination and source specifiers
//   EU_RegWriteE..MemWriteE    : registered control
//   EU_BusyE                   : multiply in progress (stall request)
module execute_unit
  import execute_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             EU_CLK,
  input  logic             EU_RST,
  input  logic             EU_RegWriteD,
  input  logic             EU_MemToRegD,
  input  logic             EU_MemWriteD,
  input  logic             EU_AluSrcD,
  input  logic             EU_RegDstD,
  input  logic [2:0]       EU_ALUControlD,
  input  logic [WIDTH-1:0] EU_R1D,
  input  logic [WIDTH-1:0] EU_R2D,
  input  logic [WIDTH-1:0] EU_SignImmD,
  input  logic [4:0]       EU_RsD,
  input  logic [4:0]       EU_RtD,
  input  logic [4:0]       EU_RdD,
  input  logic             EU_StallE,
  input  logic             EU_FlushE,
  input  logic [1:0]       EU_ForwardAE,
  input  logic [1:0]       EU_ForwardBE,
  input  logic [WIDTH-1:0] EU_ALUOutM,
  input  logic [WIDTH-1:0] EU_ResultW,
  output logic [WIDTH-1:0] EU_ALUOutE,
  output logic [WIDTH-1:0] EU_WriteDataE,
  output logic [4:0]       EU_WriteRegE,
  output logic [4:0]       EU_RsE,
  output logic [4:0]       EU_RtE,
  output logic             EU_RegWriteE,
  output logic             EU_MemToRegE,
  output logic             EU_MemWriteE,
  output logic             EU_BusyE
);

  ctrl_t            ctrl_d;
  ctrl_t            ctrl_e;
  logic [WIDTH-1:0] r1_e;
  logic [WIDTH-1:0] r2_e;
  logic [WIDTH-1:0] imm_e;
  logic [4:0]       rd_e;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] fwd_b;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] alu_result;
  logic             lt;

  assign ctrl_d = {EU_RegWriteD, EU_MemToRegD, EU_MemWriteD,
                   EU_AluSrcD, EU_RegDstD, EU_ALUControlD};

  DTOEFF #(.WIDTH(WIDTH)) u_dtoeff (
    .clk    (EU_CLK),
    .rst_n  (EU_RST),
    .en     (~EU_StallE),
    .clr    (EU_FlushE),
    .ctrl_d (ctrl_d),
    .r1_d   (EU_R1D),
    .r2_d   (EU_R2D),
    .imm_d  (EU_SignImmD),
    .rs_d   (EU_RsD),
    .rt_d   (EU_RtD),
    .rd_d   (EU_RdD),
    .ctrl_e (ctrl_e),
    .r1_e   (r1_e),
    .r2_e   (r2_e),
    .imm_e  (imm_e),
    .rs_e   (EU_RsE),
    .rt_e   (EU_RtE),
    .rd_e   (rd_e)
  );

  assign EU_RegWriteE = ctrl_e.reg_write;
  assign EU_MemToRegE = ctrl_e.mem_to_reg;
  assign EU_MemWriteE = ctrl_e.mem_write;
  assign EU_WriteRegE = ctrl_e.reg_dst ? rd_e : EU_RtE;

  always_comb begin
    case (EU_ForwardAE)
      FWD_RESULT_W: src_a = EU_ResultW;
      FWD_ALUOUT_M: src_a = EU_ALUOutM;
      default:      src_a = r1_e;
    endcase
  end

  always_comb begin
    case (EU_ForwardBE)
      FWD_RESULT_W: fwd_b = EU_ResultW;
      FWD_ALUOUT_M: fwd_b = EU_ALUOutM;
      default:      fwd_b = r2_e;
    endcase
  end

  assign src_b         = ctrl_e.alu_src ? imm_e : fwd_b;
  assign EU_WriteDataE = fwd_b;
  assign lt            = $signed(src_a) < $signed(src_b);

`ifdef EXECUTE_UNIT_MULT_EN
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  mul_state_e       state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [CW-1:0]    count;
  logic             is_mul;

  assign is_mul   = (ctrl_e.alu_control == ALU_MUL);
  assign EU_BusyE = is_mul && (state != MUL_DONE);

  // Operands are captured on IDLE->RUN so later forward-path changes
  // cannot disturb the product; only the low WIDTH bits are kept.
  always_ff @(posedge EU_CLK or negedge EU_RST) begin
    if (!EU_RST) begin
      state <= MUL_IDLE;
      acc   <= '0;
      mul_a <= '0;
      mul_b <= '0;
      count <= '0;
    end else if (EU_FlushE) begin
      state <= MUL_IDLE;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (is_mul) begin
            mul_a <= src_a;
            mul_b <= src_b;
            acc   <= '0;
            count <= '0;
            state <= MUL_RUN;
          end
        end
        MUL_RUN: begin
          if (mul_b[0]) begin
            acc <= acc + mul_a;
          end
          mul_a <= mul_a << 1;
          mul_b <= mul_b >> 1;
          count <= count + 1'b1;
          if (count == LAST_ITER) begin
            state <= MUL_DONE;
          end
        end
        MUL_DONE: begin
          if (!EU_StallE) begin
            state <= MUL_IDLE;
          end
        end
        default: state <= MUL_IDLE;
      endcase
    end
  end
`else
  assign EU_BusyE = 1'b0;
`endif

  always_comb begin
    alu_result = '0;
    case (ctrl_e.alu_control)
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_SLT: alu_result[0] = lt;
`ifdef EXECUTE_UNIT_MULT_EN
      ALU_MUL: alu_result = (state == MUL_DONE) ? acc : '0;
`endif
      default: alu_result = '0;
    endcase
  end

  // Forwarded inputs reach the ALU even while the register is in reset,
  // so the result is forced low for the duration of reset.
  assign EU_ALUOutE = EU_RST ? alu_result : '0;

endmodule

// File: tb/tb_execute_unit.sv
module tb_execute_unit;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         rw_d, mtr_d, mw_d, as_d, rdst_d;
  logic [2:0]   op_d;
  logic [W-1:0] r1_d, r2_d, imm_d;
  logic [4:0]   rs_d, rt_d, rd_d;
  logic         stall, flush;
  logic [1:0]   fwd_a, fwd_b;
  logic [W-1:0] alu_m, res_w;

  logic [W-1:0] alu_e, wd_e;
  logic [4:0]   wr_e, rs_e, rt_e;
  logic         rw_e, mtr_e, mw_e, busy_e;

  int checks   = 0;
  int failures = 0;

  execute_unit #(.WIDTH(W)) dut (
    .EU_CLK         (clk),
    .EU_RST         (rst),
    .EU_RegWriteD   (rw_d),
    .EU_MemToRegD   (mtr_d),
    .EU_MemWriteD   (mw_d),
    .EU_AluSrcD     (as_d),
    .EU_RegDstD     (rdst_d),
    .EU_ALUControlD (op_d),
    .EU_R1D         (r1_d),
    .EU_R2D         (r2_d),
    .EU_SignImmD    (imm_d),
    .EU_RsD         (rs_d),
    .EU_RtD         (rt_d),
    .EU_RdD         (rd_d),
    .EU_StallE      (stall),
    .EU_FlushE      (flush),
    .EU_ForwardAE   (fwd_a),
    .EU_ForwardBE   (fwd_b),
    .EU_ALUOutM     (alu_m),
    .EU_ResultW     (res_w),
    .EU_ALUOutE     (alu_e),
    .EU_WriteDataE  (wd_e),
    .EU_WriteRegE   (wr_e),
    .EU_RsE         (rs_e),
    .EU_RtE         (rt_e),
    .EU_RegWriteE   (rw_e),
    .EU_MemToRegE   (mtr_e),
    .EU_MemWriteE   (mw_e),
    .EU_BusyE       (busy_e)
  );

  // Reference view of what the execute stage currently holds.
  typedef struct packed {
    logic         rw, mtr, mw, as, rdst;
    logic [2:0]   op;
    logic [W-1:0] r1, r2, imm;
    logic [4:0]   rs, rt, rd;
  } stage_t;
  stage_t m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (op)
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b111:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: return '0;
    endcase
  endfunction

  function automatic logic [W-1:0] fwd_val(input logic [1:0] sel, input logic [W-1:0] reg_v);
    if (sel == 2'b01) return res_w;
    if (sel == 2'b10) return alu_m;
    return reg_v;
  endfunction

  task automatic check_all();
    logic [W-1:0] a, b;
    a = fwd_val(fwd_a, m.r1);
    b = fwd_val(fwd_b, m.r2);
    chk("alu_out", alu_e, ref_alu(m.op, a, m.as ? m.imm : b));
    chk("write_data", wd_e, b);
    chk("write_reg", 32'(wr_e), 32'(m.rdst ? m.rd : m.rt));
    chk("rs_e", 32'(rs_e), 32'(m.rs));
    chk("rt_e", 32'(rt_e), 32'(m.rt));
    chk("ctrl_e", 32'({rw_e, mtr_e, mw_e}), 32'({m.rw, m.mtr, m.mw}));
    chk("busy", 32'(busy_e), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_alu"}, alu_e, '0);
    chk({tag, "_wd"}, wd_e, '0);
    chk({tag, "_wr"}, 32'(wr_e), '0);
    chk({tag, "_rsrt"}, 32'({rs_e, rt_e}), '0);
    chk({tag, "_ctrl"}, 32'({rw_e, mtr_e, mw_e}), '0);
    chk({tag, "_busy"}, 32'(busy_e), '0);
  endtask

  task automatic clk_step();
    @(posedge clk);
    if (flush) m = '0;
    else if (!stall) m = {rw_d, mtr_d, mw_d, as_d, rdst_d, op_d, r1_d, r2_d, imm_d, rs_d, rt_d, rd_d};
    #1;
    check_all();
  endtask

  task automatic rand_d();
    {rw_d, mtr_d, mw_d, as_d, rdst_d} = 5'($urandom);
    op_d  = 3'($urandom_range(0, 7));
`ifdef EXECUTE_UNIT_MULT_EN
    if (op_d == 3'b011) op_d = 3'b010;
`endif
    r1_d  = $urandom;
    r2_d  = $urandom;
    imm_d = $urandom;
    rs_d  = 5'($urandom);
    rt_d  = 5'($urandom);
    rd_d  = 5'($urandom);
  endtask

  task automatic zero_d();
    {rw_d, mtr_d, mw_d, as_d, rdst_d} = '0;
    op_d = 3'b000; r1_d = '0; r2_d = '0; imm_d = '0;
    rs_d = '0; rt_d = '0; rd_d = '0;
  endtask

`ifdef EXECUTE_UNIT_MULT_EN
  // Starts a multiply (A via ALUOutM forwarding, B from R2), holds stall while
  // busy, perturbs the forward path after operand capture, and optionally
  // flushes or resets at a given busy cycle.
  task automatic mul_run(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int abort_at, input bit use_reset);
    int nbusy;
    zero_d();
    op_d = 3'b011; r1_d = $urandom; r2_d = b;
    fwd_a = 2'b10; fwd_b = 2'b00; alu_m = a;
    stall = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    stall = 1'b1;
    rand_d();
    nbusy = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy_e) break;
      nbusy++;
      if (nbusy == 2) alu_m = ~a;
      if (abort_at != 0 && nbusy == abort_at) begin
        fwd_a = 2'b00;
        if (use_reset) begin
          rst = 1'b0;
          #1;
          check_zero("mul_reset");
          zero_d();
          stall = 1'b0;
          @(posedge clk); #1;
          check_zero("mul_reset_hold");
          @(negedge clk);
          rst = 1'b1;
          @(posedge clk); #1;
          check_zero("mul_reset_release");
        end else begin
          flush = 1'b1;
          @(posedge clk); #1;
          flush = 1'b0;
          check_zero("mul_flush");
          zero_d();
          stall = 1'b0;
          @(posedge clk); #1;
          check_zero("mul_flush_after");
        end
        return;
      end
      @(posedge clk); #1;
    end
    chk("mul_busy_cycles", 32'(nbusy), 32'(W + 1));
    chk("mul_product", alu_e, a * b);
    @(posedge clk); #1;
    chk("mul_done_hold", alu_e, a * b);
    chk("mul_done_busy", 32'(busy_e), '0);
    zero_d();
    fwd_a = 2'b00;
    stall = 1'b0;
    @(posedge clk); #1;
    chk("mul_after_alu", alu_e, '0);
    chk("mul_after_busy", 32'(busy_e), '0);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    stall = 1'b0; flush = 1'b0;
    fwd_a = 2'b00; fwd_b = 2'b00;
    alu_m = $urandom; res_w = $urandom;
    rand_d();
    op_d = 3'b010;
    #2 rst = 1'b0;
    #1 check_zero("reset");
    repeat (2) @(posedge clk);
    #1 check_zero("reset_clocked");
    @(negedge clk);
    rst = 1'b1;
    m = '0;

    zero_d();
    r1_d = 32'd5; r2_d = 32'd7; op_d = 3'b010;
    clk_step();
    chk("add_5_7", alu_e, 32'd12);

    r1_d = 32'hFFFF_FFFF; r2_d = 32'd1; op_d = 3'b111;
    clk_step();
    chk("slt_neg", alu_e, 32'd1);

    r1_d = 32'd0; r2_d = 32'd1; op_d = 3'b110;
    clk_step();
    chk("sub_wrap", alu_e, 32'hFFFF_FFFF);

    r1_d = 32'h5555; r2_d = 32'hAAAA; op_d = 3'b001;
    fwd_a = 2'b10; alu_m = 32'h100; fwd_b = 2'b01; res_w = 32'h23;
    clk_step();
    chk("fwd_or", alu_e, 32'h123);

    stall = 1'b1;
    rand_d();
    clk_step();
    chk("stall_hold", alu_e, 32'h123);

    flush = 1'b1;
    fwd_a = 2'b00; fwd_b = 2'b00;
    clk_step();
    chk("flush_over_stall", alu_e, '0);
    stall = 1'b0; flush = 1'b0;

    zero_d();
    op_d = 3'b010; as_d = 1'b1; rdst_d = 1'b1;
    r1_d = 32'd100; r2_d = 32'd9; imm_d = 32'hFFFF_FFFC; rt_d = 5'd3; rd_d = 5'd17;
    clk_step();
    chk("imm_add", alu_e, 32'd96);
    chk("regdst_rd", 32'(wr_e), 32'd17);

`ifndef EXECUTE_UNIT_MULT_EN
    zero_d();
    op_d = 3'b011; r1_d = 32'd6; r2_d = 32'd7;
    clk_step();
    chk("mul_disabled_alu", alu_e, '0);
    chk("mul_disabled_busy", 32'(busy_e), '0);
`endif

    for (int i = 0; i < 300; i++) begin
      rand_d();
      fwd_a = 2'($urandom); fwd_b = 2'($urandom);
      alu_m = $urandom; res_w = $urandom;
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      clk_step();
    end
    stall = 1'b0; flush = 1'b0;
    fwd_a = 2'b00; fwd_b = 2'b00;
    zero_d();
    @(posedge clk); #1;

`ifdef EXECUTE_UNIT_MULT_EN
    mul_run(32'd6, 32'd7, 0, 1'b0);
    mul_run(32'd6, 32'd7, 0, 1'b0);
    mul_run($urandom, $urandom, 0, 1'b0);
    mul_run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    mul_run(32'd9, 32'd11, 10, 1'b0);
    mul_run(32'd13, 32'd3, 0, 1'b0);
    mul_run(32'd21, 32'd5, 6, 1'b1);
    mul_run(32'd21, 32'd5, 0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
